// File: rtl/lock_code_sender.sv
// lock_code_sender: serialises a latched binary unlock code onto the lock's
// 2-bit key bus, MSB first, then waits a bounded time for the lock to report
// that it opened. Every output is a register loaded with the value for the
// state being entered.
module lock_code_sender #(
    parameter int unsigned CODE_LEN = 4,
    parameter int unsigned GAP      = 2,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [CODE_LEN-1:0] i_code,
    input  logic                i_abort,
    input  logic                i_unlocked,
    output logic [1:0]          o_key_out,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_success,
    output logic                o_fail
);

    localparam int unsigned SYM_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int unsigned GAP_W = (GAP > 1)      ? $clog2(GAP)      : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1)  ? $clog2(TIMEOUT)  : 1;

    localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(CODE_LEN - 1);
    // With GAP = 0 the GAP state is never entered, so the wrapped value is unused.
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP - 1);
    localparam logic [TO_W-1:0]  LAST_TO  = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] KEY_ONE  = 2'b10;
    localparam logic [1:0] KEY_ZERO = 2'b01;
    localparam logic [1:0] KEY_NONE = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_WAIT,
        ST_FINISH
    } state_t;

    state_t              r_state;
    logic [CODE_LEN-1:0] r_shift;
    logic [SYM_W-1:0]    r_sym_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [TO_W-1:0]     r_to_cnt;

    logic [CODE_LEN-1:0] w_shift_next;
    logic                w_last_sym;

    // Code bit to key symbol; never produces 2'b11.
    function automatic logic [1:0] f_key(input logic b);
        return b ? KEY_ONE : KEY_ZERO;
    endfunction

    // Shift register after the current symbol has been consumed.
    assign w_shift_next = r_shift << 1;
    assign w_last_sym   = (r_sym_cnt == LAST_SYM);

    // Sequencer: state, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_sym_cnt <= '0;
            r_gap_cnt <= '0;
            r_to_cnt  <= '0;
            o_key_out <= KEY_NONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_success <= 1'b0;
            o_fail    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    o_key_out <= KEY_NONE;
                    o_busy    <= 1'b0;
                    if (i_start && !i_abort) begin
                        r_shift   <= i_code;
                        r_sym_cnt <= '0;
                        r_gap_cnt <= '0;
                        r_to_cnt  <= '0;
                        o_success <= 1'b0;
                        o_fail    <= 1'b0;
                        o_busy    <= 1'b1;
                        o_key_out <= f_key(i_code[CODE_LEN-1]);
                        r_state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (i_abort) begin
                        o_key_out <= KEY_NONE;
                        o_done    <= 1'b1;
                        o_success <= 1'b0;
                        o_fail    <= 1'b1;
                        r_state   <= ST_FINISH;
                    end else begin
                        r_shift   <= w_shift_next;
                        r_sym_cnt <= r_sym_cnt + SYM_W'(1);
                        if (w_last_sym) begin
                            r_to_cnt  <= '0;
                            o_key_out <= KEY_NONE;
                            r_state   <= ST_WAIT;
                        end else if (GAP == 0) begin
                            o_key_out <= f_key(w_shift_next[CODE_LEN-1]);
                            r_state   <= ST_SEND;
                        end else begin
                            r_gap_cnt <= '0;
                            o_key_out <= KEY_NONE;
                            r_state   <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (i_abort) begin
                        o_key_out <= KEY_NONE;
                        o_done    <= 1'b1;
                        o_success <= 1'b0;
                        o_fail    <= 1'b1;
                        r_state   <= ST_FINISH;
                    end else if (r_gap_cnt == LAST_GAP) begin
                        o_key_out <= f_key(r_shift[CODE_LEN-1]);
                        r_state   <= ST_SEND;
                    end else begin
                        o_key_out <= KEY_NONE;
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end

                ST_WAIT: begin
                    o_key_out <= KEY_NONE;
                    if (i_abort) begin
                        o_done    <= 1'b1;
                        o_success <= 1'b0;
                        o_fail    <= 1'b1;
                        r_state   <= ST_FINISH;
                    end else if (i_unlocked) begin
                        // Checked before the timeout so a last-cycle unlock still succeeds.
                        o_done    <= 1'b1;
                        o_success <= 1'b1;
                        o_fail    <= 1'b0;
                        r_state   <= ST_FINISH;
                    end else if (r_to_cnt == LAST_TO) begin
                        o_done    <= 1'b1;
                        o_success <= 1'b0;
                        o_fail    <= 1'b1;
                        r_state   <= ST_FINISH;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                ST_FINISH: begin
                    o_key_out <= KEY_NONE;
                    o_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end

                default: begin
                    o_key_out <= KEY_NONE;
                    o_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_code_sender.sv
// Bench for lock_code_sender: a table of directed transactions and random
// transactions, each checked cycle by cycle against a timeline model, plus
// hand sequences for reset, Start+Abort in IDLE and back-to-back symbols.
module tb_lock_code_sender;

    localparam int unsigned L  = 4;
    localparam int unsigned G  = 2;
    localparam int unsigned T  = 16;
    localparam int unsigned W0 = 1 + (L - 1) * (G + 1) + 1;
    localparam int MAXC = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, abort, unlocked;
    logic [L-1:0] code;
    logic [1:0]   key;
    logic         busy, done, succ, fail;

    logic         start0, abort0, unl0;
    logic [3:0]   code0;
    logic [1:0]   key0;
    logic         busy0, done0, succ0, fail0;

    int errors = 0;
    int checks = 0;

    bit unl_sched[MAXC];

    typedef struct {
        logic [3:0] code;
        int         abort_t;
        int         unl_a;
        int         unl_b;
        int         exp_d;
        bit         exp_s;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    lock_code_sender #(.CODE_LEN(L), .GAP(G), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_code(code),
        .i_abort(abort), .i_unlocked(unlocked), .o_key_out(key),
        .o_busy(busy), .o_done(done), .o_success(succ), .o_fail(fail)
    );

    lock_code_sender #(.CODE_LEN(4), .GAP(0), .TIMEOUT(4)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_code(code0),
        .i_abort(abort0), .i_unlocked(unl0), .o_key_out(key0),
        .o_busy(busy0), .o_done(done0), .o_success(succ0), .o_fail(fail0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle of the Done pulse and the result, from the timeline rules:
    // abort in any busy cycle, unlock only inside the WAIT window, timeout at its end.
    function automatic void model(input int abort_t, output int d, output bit s);
        d = 0;
        s = 1'b0;
        for (int t = 1; t < int'(W0 + T); t++) begin
            if (t == abort_t) begin
                d = t + 1; s = 1'b0; return;
            end
            if (t >= int'(W0) && unl_sched[t]) begin
                d = t + 1; s = 1'b1; return;
            end
            if (t == int'(W0 + T - 1)) begin
                d = t + 1; s = 1'b0; return;
            end
        end
    endfunction

    // Expected {key, busy, done, success, fail} during cycle t.
    function automatic logic [5:0] expect_at(input int t, input int d, input bit s, input logic [3:0] c);
        logic [1:0] k;
        int slot;
        k = 2'b00;
        if (t < d && ((t - 1) % int'(G + 1)) == 0) begin
            slot = (t - 1) / int'(G + 1);
            if (slot < int'(L)) k = c[int'(L) - 1 - slot] ? 2'b10 : 2'b01;
        end
        return {k, 1'(t <= d), 1'(t == d), 1'(t >= d && s), 1'(t >= d && !s)};
    endfunction

    task automatic clear_sched();
        foreach (unl_sched[i]) unl_sched[i] = 1'b0;
    endtask

    // One transaction: Start at edge 0, then per-cycle compare with the model.
    task automatic run_txn(input string tag, input logic [3:0] c, input int abort_t,
                           output int d_seen, output bit s_seen);
        int d;
        bit s;
        logic [5:0] act;
        model(abort_t, d, s);
        d_seen = 0;
        @(negedge clk);
        start = 1'b1; code = c; abort = 1'b0; unlocked = 1'b0;
        @(negedge clk);
        for (int t = 1; t <= d + 1; t++) begin
            act = {key, busy, done, succ, fail};
            check($sformatf("%s cyc%0d", tag, t), 32'(act), 32'(expect_at(t, d, s, c)));
            if (done && d_seen == 0) d_seen = t;
            start    = (t < d) ? 1'($urandom_range(0, 1)) : 1'b0;
            code     = L'($urandom);
            unlocked = unl_sched[t];
            abort    = (t == abort_t);
            @(negedge clk);
        end
        s_seen = succ;
        start = 1'b0; abort = 1'b0; unlocked = 1'b0;
    endtask

    initial begin
        int d_seen;
        bit s_seen;
        logic [1:0] exp_k0 [1:10];

        vecs[0] = '{4'b1001,  0, 13,  0, 14, 1'b1};
        vecs[1] = '{4'b1001,  0,  0,  0, 27, 1'b0};
        vecs[2] = '{4'b1011,  3,  0,  0,  4, 1'b0};
        vecs[3] = '{4'b0110,  0, 26,  0, 27, 1'b1};
        vecs[4] = '{4'b1111,  0,  5, 10, 27, 1'b0};
        vecs[5] = '{4'b0000,  0, 11,  0, 12, 1'b1};
        vecs[6] = '{4'b1100, 20, 20,  0, 21, 1'b0};
        vecs[7] = '{4'b0101, 16, 15,  0, 16, 1'b1};

        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; unlocked = 1'b0; code = '0;
        start0 = 1'b0; abort0 = 1'b0; unl0 = 1'b0; code0 = '0;
        clear_sched();

        #12;
        check("reset_outputs", 32'({key, busy, done, succ, fail}), 32'd0);
        check("reset_outputs_gap0", 32'({key0, busy0, done0, succ0, fail0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int v = 0; v < 8; v++) begin
            clear_sched();
            if (vecs[v].unl_a != 0) unl_sched[vecs[v].unl_a] = 1'b1;
            if (vecs[v].unl_b != 0) unl_sched[vecs[v].unl_b] = 1'b1;
            run_txn($sformatf("tab%0d", v), vecs[v].code, vecs[v].abort_t, d_seen, s_seen);
            check($sformatf("tab%0d done_cycle", v), 32'(d_seen), 32'(vecs[v].exp_d));
            check($sformatf("tab%0d success", v), 32'(s_seen), 32'(vecs[v].exp_s));
        end

        // Start and Abort together in IDLE: Start ignored
        @(negedge clk);
        start = 1'b1; abort = 1'b1; code = 4'b1111;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'({key, busy, done}), 32'd0);
        @(negedge clk);
        check("start_abort_idle2", 32'({key, busy, done}), 32'd0);

        // Reset in the middle of SEND, then a clean restart
        start = 1'b1; code = 4'b1011;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_key", 32'({key, busy}), 32'({2'b01, 1'b1}));
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'({key, busy, done, succ, fail}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", i), 32'({key, busy, done, succ, fail}), 32'd0);
        end
        clear_sched();
        run_txn("restart", 4'b1011, 0, d_seen, s_seen);
        check("restart done_cycle", 32'(d_seen), 32'd27);

        // Back-to-back symbols with GAP = 0, TIMEOUT = 4
        exp_k0[1] = 2'b01; exp_k0[2] = 2'b10; exp_k0[3] = 2'b10; exp_k0[4] = 2'b01;
        for (int t = 5; t <= 10; t++) exp_k0[t] = 2'b00;
        @(negedge clk);
        start0 = 1'b1; code0 = 4'b0110;
        @(negedge clk);
        start0 = 1'b0; code0 = 4'b1111;
        for (int t = 1; t <= 10; t++) begin
            check($sformatf("gap0 cyc%0d", t), 32'({key0, busy0, done0, succ0, fail0}),
                  32'({exp_k0[t], 1'(t <= 9), 1'(t == 9), 1'b0, 1'(t >= 9)}));
            @(negedge clk);
        end

        // Random transactions
        for (int n = 0; n < 24; n++) begin
            logic [3:0] rc;
            int ab;
            clear_sched();
            for (int t = 1; t < MAXC; t++) unl_sched[t] = ($urandom_range(0, 11) == 0);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 28)) : 0;
            rc = 4'($urandom);
            run_txn($sformatf("rnd%0d", n), rc, ab, d_seen, s_seen);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lock_code_sender.md
Name: lock_code_sender

Overview:
- Transmit side of the automatic-lock keypad interface.
- Takes a stored binary unlock code and serialises it onto the lock's 2-bit key-input bus:
  - `2'b10` = key '1'
  - `2'b01` = key '0'
  - `2'b00` = no key
- Each key press lasts exactly one clock and is followed by programmable idle gaps.
- After the last key it waits a bounded time for the lock's unlocked indication and reports success or failure.

Parameters:
- CODE_LEN, 4, number of key symbols per code (≥1).
- GAP, 2, idle (`2'b00`) cycles inserted between consecutive symbols (≥0).
- TIMEOUT, 16, maximum cycles to wait for Unlocked after the last symbol (≥1).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request to send Code; sampled only in IDLE.
- Code  input  CODE_LEN  code to send, MSB sent first; latched when Start is accepted.
- Abort  input  1  cancel an in-progress transmission.
- Unlocked  input  1  feedback from the lock, high when the lock reached its open state.
- Key_Out  output  2  registered key symbol driven to the lock's Input bus.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when an operation finishes (success, timeout or abort).
- Success  output  1  sticky result flag, valid from the Done pulse until the next accepted Start.
- Fail  output  1  sticky result flag, complement of Success after a completed operation.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - State = IDLE.
  - Key_Out = 00; Busy = 0, Done = 0, Success = 0, Fail = 0.
  - Shift register and all counters cleared.
  - A reset in mid-operation drops Key_Out to 00 immediately, with no Done pulse.
- All outputs are registered.
- Symbol mapping: code bit 1 → 10, bit 0 → 01. Key_Out is never 11.
- States: IDLE, SEND, GAP, WAIT, FINISH.
- IDLE:
  - Key_Out = 00.
  - On Start=1 and Abort=0: latch Code into the shift register, clear the symbol counter, clear Success and Fail, go to SEND.
- SEND:
  - Key_Out = mapped MSB of the shift register, held exactly one cycle.
  - Then shift left and increment the symbol count.
  - If this was symbol CODE_LEN-1, go to WAIT.
  - Otherwise go to GAP, or straight to SEND when GAP=0 (back-to-back symbols).
- GAP:
  - Key_Out = 00 for exactly GAP cycles, then SEND.
- WAIT:
  - Key_Out = 00; a timeout counter counts cycles.
  - Unlocked=1 in any WAIT cycle → FINISH with Success=1.
  - After TIMEOUT cycles without Unlocked → FINISH with Fail=1.
  - If Unlocked and the final timeout cycle coincide, Success wins.
- FINISH:
  - Done = 1 for one cycle, then IDLE.
- Unlocked is ignored outside WAIT.
- Timing, with Start sampled at edge 0:
  - Symbol i is on Key_Out during cycle 1 + i·(GAP+1).
  - WAIT begins the cycle after the last symbol.
- Abort=1 in SEND, GAP or WAIT:
  - Next cycle Key_Out = 00, Done pulses, Fail = 1, Success = 0.
  - Then IDLE.
  - Abort takes priority over Unlocked and timeout in the same cycle.
- Abort in IDLE or FINISH has no effect.
- Start while Busy is ignored; Code changes while Busy are ignored.
- Start and Abort together in IDLE: Start is ignored.

Test Plan:
- Reset_n low mid-SEND with Code=4'b1011 → Key_Out = 00 asynchronously, all flags 0, no Done pulse; a subsequent Start restarts from symbol 0.
- CODE_LEN=4, GAP=2, Code=4'b1001, Start one cycle → Key_Out sequence 10,00,00,01,00,00,01,00,00,10 then 00; Busy=1 throughout. Unlocked=1 on the 3rd WAIT cycle → Done pulse, Success=1, Fail=0.
- Same code, Unlocked held 0 → after 16 WAIT cycles Done pulses with Fail=1, Success=0; Busy falls the cycle after Done.
- GAP=0, Code=4'b0110 → Key_Out = 01,10,10,01 on four consecutive cycles, then WAIT.
- Abort during the second GAP cycle → next cycle Key_Out = 00, Done pulses, Fail=1. A Start during the busy period is ignored, shown by the sequence not restarting.
- Unlocked=1 pulsed during SEND/GAP only, never in WAIT → result is Fail after timeout; Unlocked on the final timeout cycle → Success=1.
